packet_scheduler: RTL

Schedules HDMI data-island packets, Spec v1.3a Section 5.2.3 and Section 5.3, on clk_pixel. Several packet sources (AVI InfoFrame, audio InfoFrame, audio clock regen, audio sample) request slots. The timing logic opens a data island. The block fills each 32-pixel packet slot with a granted source packet or a null packet. Its output feeds the packet assembler (ECC/BCH, TMDS serialisation) that drives data_island_data.

---
 rtl/hdmi_packet_pkg.sv | 37 +++
 rtl/packet_arbiter.sv | 63 ++++++
 rtl/packet_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hdmi_packet_pkg.sv
// ============================================================================
// Module   : hdmi_packet_pkg
// Purpose  : Shared widths, constants, packet type codes and the scheduler
//            state type for the HDMI data-island packet path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hdmi_packet_pkg;

  // Packet geometry (header and subpackets exclude ECC/BCH parity)
  localparam int HEADER_W   = 24;
  localparam int SUBPKT_W   = 56;
  localparam int NUM_SUBPKT = 4;
  localparam int SUB_W      = SUBPKT_W * NUM_SUBPKT;

  // Island timing
  localparam int SLOT_CYCLES        = 32;
  localparam int MAX_ISLAND_PACKETS = 18;

  // Packet type codes (HB0)
  localparam logic [7:0] PKT_TYPE_NULL  = 8'h00;
  localparam logic [7:0] PKT_TYPE_ACR   = 8'h01;
  localparam logic [7:0] PKT_TYPE_AUDIO = 8'h02;
  localparam logic [7:0] PKT_TYPE_AVI   = 8'h82;
  localparam logic [7:0] PKT_TYPE_AIF   = 8'h84;

  localparam logic [HEADER_W-1:0] NULL_HEADER = {16'h0000, PKT_TYPE_NULL};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/packet_arbiter.sv
// ============================================================================
// Module   : packet_arbiter
// Purpose  : Combinational slot arbiter. Unsent mandatory sources win first
//            (lowest index); otherwise round-robin from ptr+1 over requesting
//            sources, excluding mandatory sources already sent this frame.
// Ports    : req       - per-source request
//            sent      - per-source sent-this-frame flag
//            ptr       - round-robin pointer (last round-robin winner)
//            win_idx   - winning source index
//            win_valid - a source won (0 = null packet)
//            win_mand  - the win came from the mandatory stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_arbiter #(
  parameter int                 NUM_SRC        = 4,
  parameter logic [NUM_SRC-1:0] MANDATORY_MASK = NUM_SRC'(4'b0001),
  parameter int                 PTR_W          = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] sent,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_valid,
  output logic               win_mand
);

  logic [NUM_SRC-1:0] elig_mand;
  logic [NUM_SRC-1:0] elig_rr;

  assign elig_mand = req & MANDATORY_MASK & ~sent;
  assign elig_rr   = req & ~(MANDATORY_MASK & sent);

  always_comb begin
    int j;
    j         = 0;
    win_idx   = '0;
    win_valid = 1'b0;
    win_mand  = 1'b0;
    // Descending scan so the last hit (lowest index) is the winner
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig_mand[i]) begin
        win_idx   = PTR_W'(i);
        win_valid = 1'b1;
        win_mand  = 1'b1;
      end
    end
    if (!win_valid) begin
      // Descending distance from the pointer: nearest source after ptr wins
      for (int k = NUM_SRC; k >= 1; k--) begin
        j = (int'(ptr) + k) % NUM_SRC;
        if (elig_rr[j]) begin
          win_idx   = PTR_W'(j);
          win_valid = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/packet_scheduler.sv
// ============================================================================
// Module   : packet_scheduler
// Purpose  : Fills each 32-cycle data-island slot with a granted source
//            packet or a null packet, tracks mandatory once-per-frame
//            sources, and flags overlapping islands.
// Ports    : clk_pixel, reset_n (async, active-low)
//            frame_start, island_start, island_packets - timing inputs
//            req, src_header, src_sub - per-source packet requests
//            grant - one-hot pulse in the cycle a source's packet is latched
//            pkt_valid, pkt_first, pkt_header, pkt_sub - slot output
//            missed, overlap_err - sticky status
// Option   : PACKET_SCHED_STATS_EN adds null_count[7:0] (null slots in the
//            previous frame, saturating at 255).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int                 NUM_SRC        = 4,
  parameter logic [NUM_SRC-1:0] MANDATORY_MASK = NUM_SRC'(4'b0001)
) (
  input  logic                        clk_pixel,
  input  logic                        reset_n,
  input  logic                        frame_start,
  input  logic                        island_start,
  input  logic [4:0]                  island_packets,
  input  logic [NUM_SRC-1:0]          req,
  input  logic [NUM_SRC*HEADER_W-1:0] src_header,
  input  logic [NUM_SRC*SUB_W-1:0]    src_sub,
  output logic [NUM_SRC-1:0]          grant,
  output logic                        pkt_valid,
  output logic                        pkt_first,
  output logic [HEADER_W-1:0]         pkt_header,
  output logic [SUB_W-1:0]            pkt_sub,
  output logic [NUM_SRC-1:0]          missed,
  output logic                        overlap_err
`ifdef PACKET_SCHED_STATS_EN
  ,
  output logic [7:0]                  null_count
`endif
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  sched_state_t       state, state_nxt;
  logic [4:0]         slot_cnt;
  logic [4:0]         pkts_left;
  logic [4:0]         island_n;
  logic [NUM_SRC-1:0] sent;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_idx;
  logic               win_valid;
  logic               win_mand;
  logic               slot_last;
  logic               start_ok;
  logic               arb_fire;

  assign slot_last = (slot_cnt == 5'(SLOT_CYCLES - 1));
  assign start_ok  = island_start && (island_packets != 5'd0);
  assign island_n  = (island_packets > 5'(MAX_ISLAND_PACKETS)) ?
                     5'(MAX_ISLAND_PACKETS) : island_packets;

  packet_arbiter #(
    .NUM_SRC        (NUM_SRC),
    .MANDATORY_MASK (MANDATORY_MASK),
    .PTR_W          (PTR_W)
  ) u_arbiter (
    .req       (req),
    .sent      (sent),
    .ptr       (rr_ptr),
    .win_idx   (win_idx),
    .win_valid (win_valid),
    .win_mand  (win_mand)
  );

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and slot-boundary arbitration strobe
  always_comb begin
    state_nxt = state;
    arb_fire  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_SEND;
          arb_fire  = 1'b1;
        end
      end
      ST_SEND: begin
        if (slot_last) begin
          if (pkts_left > 5'd1) arb_fire  = 1'b1;
          else                  state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    if (arb_fire && win_valid) grant[win_idx] = 1'b1;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      pkt_valid   <= 1'b0;
      pkt_first   <= 1'b0;
      pkt_header  <= '0;
      pkt_sub     <= '0;
      slot_cnt    <= '0;
      pkts_left   <= '0;
      rr_ptr      <= '0;
      sent        <= '0;
      missed      <= '0;
      overlap_err <= 1'b0;
    end else begin
      pkt_first <= 1'b0;
      if (arb_fire) begin
        pkt_valid <= 1'b1;
        pkt_first <= 1'b1;
        slot_cnt  <= '0;
        pkts_left <= (state == ST_IDLE) ? island_n : pkts_left - 5'd1;
        if (win_valid) begin
          pkt_header <= src_header[win_idx*HEADER_W +: HEADER_W];
          pkt_sub    <= src_sub[win_idx*SUB_W +: SUB_W];
          if (!win_mand) rr_ptr <= win_idx;
        end else begin
          pkt_header <= NULL_HEADER;
          pkt_sub    <= '0;
        end
      end else if (state == ST_SEND) begin
        slot_cnt <= slot_cnt + 5'd1;
        // Only the final slot reaches its last cycle without arb_fire
        if (slot_last) pkt_valid <= 1'b0;
      end

      if (island_start && (state == ST_SEND)) overlap_err <= 1'b1;

      // A grant in the frame_start cycle counts as sent before the check
      if (frame_start) begin
        missed <= missed | (MANDATORY_MASK & ~(sent | grant));
        sent   <= '0;
      end else begin
        sent   <= sent | grant;
      end
    end
  end

`ifdef PACKET_SCHED_STATS_EN
  logic [7:0] null_cnt;
  logic       null_slot;

  assign null_slot = arb_fire && !win_valid;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      null_cnt   <= '0;
      null_count <= '0;
    end else if (frame_start) begin
      null_count <= null_cnt;
      null_cnt   <= null_slot ? 8'd1 : 8'd0;
    end else if (null_slot && (null_cnt != 8'hFF)) begin
      null_cnt   <= null_cnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire
